// File: rtl/ysyx_22051013_pipe_ctl.sv
// Central 5-stage pipeline sequencer: stage enables/flushes, wrong-path fetch kill and LSU timeout.
// Optional perf counters are enabled with the PIPE_CTL_PERF_EN macro.
module ysyx_22051013_pipe_ctl #(
  parameter int LS_TIMEOUT = 255,
  parameter int TCNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ready_i,
  input  logic        id_load_use_i,
  input  logic        id_jump_i,
  input  logic        ex_busy_i,
  input  logic        ls_req_i,
  input  logic        ls_ack_i,
  output logic        pc_en_o,
  output logic        ifid_en_o,
  output logic        idex_en_o,
  output logic        exls_en_o,
  output logic        lswb_en_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        exls_flush_o,
  output logic        lswb_flush_o,
  output logic [1:0]  state_o,
  output logic        bus_err_o,
  output logic [63:0] stall_cycles_o,
  output logic [63:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_WAIT = 2'd1,
    LS_WAIT = 2'd2,
    ERR     = 2'd3
  } state_t;

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(LS_TIMEOUT - 1);

  state_t              state, state_nxt;
  logic                kill, kill_nxt;
  logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
  logic                ls_stall, ex_stall, lu, jmp, fetch_ok;

  // A redirect is only trusted once neither the LSU nor EX is holding its operands.
  assign ls_stall = ls_req_i & ~ls_ack_i;
  assign ex_stall = ex_busy_i & ~ls_stall;
  assign lu       = id_load_use_i & ~ls_stall & ~ex_busy_i;
  assign jmp      = id_jump_i & ~ls_stall & ~ex_busy_i & ~id_load_use_i;
  assign fetch_ok = if_ready_i & ~kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      kill  <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = '0;
    kill_nxt  = kill;
    case (state)
      RUN: begin
        if (ls_stall)      state_nxt = LS_WAIT;
        else if (ex_stall) state_nxt = EX_WAIT;
      end
      EX_WAIT: begin
        if (ls_stall)        state_nxt = LS_WAIT;
        else if (!ex_busy_i) state_nxt = RUN;
      end
      LS_WAIT: begin
        if (ls_ack_i || !ls_req_i) state_nxt = RUN;
        else if (tcnt == TCNT_LAST) state_nxt = ERR;
        else tcnt_nxt = (&tcnt) ? tcnt : tcnt + TCNT_W'(1);
      end
      default: state_nxt = RUN;
    endcase
    // A redirect while a wrong-path fetch is outstanding keeps the next returning fetch doomed.
    if (state == ERR)                           kill_nxt = 1'b0;
    else if (jmp && (!if_ready_i || kill))      kill_nxt = 1'b1;
    else if (kill && if_ready_i)                kill_nxt = 1'b0;
  end

  always_comb begin
    pc_en_o      = 1'b0;
    ifid_en_o    = 1'b0;
    idex_en_o    = 1'b0;
    exls_en_o    = 1'b0;
    lswb_en_o    = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    exls_flush_o = 1'b0;
    lswb_flush_o = 1'b0;
    bus_err_o    = 1'b0;
    if (!rst || state == ERR) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      exls_flush_o = 1'b1;
      lswb_flush_o = 1'b1;
      bus_err_o    = rst;
    end else if (ls_stall) begin
      lswb_flush_o = 1'b1;
    end else if (ex_stall) begin
      exls_flush_o = 1'b1;
      lswb_en_o    = 1'b1;
    end else if (lu) begin
      idex_flush_o = 1'b1;
      exls_en_o    = 1'b1;
      lswb_en_o    = 1'b1;
    end else if (jmp) begin
      pc_en_o      = 1'b1;
      ifid_flush_o = 1'b1;
      idex_en_o    = 1'b1;
      exls_en_o    = 1'b1;
      lswb_en_o    = 1'b1;
    end else begin
      pc_en_o      = fetch_ok;
      ifid_flush_o = ~fetch_ok;
      ifid_en_o    = 1'b1;
      idex_en_o    = 1'b1;
      exls_en_o    = 1'b1;
      lswb_en_o    = 1'b1;
    end
  end

  assign state_o = state;

`ifdef PIPE_CTL_PERF_EN
  logic flush_evt;

  // Only redirect squashes and killed wrong-path fetches count as flushes, not idle bubbles.
  assign flush_evt = rst && (state != ERR) && !ls_stall && !ex_busy_i && !id_load_use_i &&
                     (id_jump_i || (kill && if_ready_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_o <= '0;
      flush_cnt_o    <= '0;
    end else begin
      if (!pc_en_o)  stall_cycles_o <= stall_cycles_o + 64'd1;
      if (flush_evt) flush_cnt_o    <= flush_cnt_o + 64'd1;
    end
  end
`else
  assign stall_cycles_o = '0;
  assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_ysyx_22051013_pipe_ctl.sv
// Bench for ysyx_22051013_pipe_ctl: directed vector table, reset corners and randomized model comparison.
module tb_ysyx_22051013_pipe_ctl;
  localparam int LS_TO = 12;
  localparam int TW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ready, ld_use, jump, ex_busy, ls_req, ls_ack;
  logic        pc_en, ifid_en, idex_en, exls_en, lswb_en;
  logic        ifid_flush, idex_flush, exls_flush, lswb_flush;
  logic [1:0]  state;
  logic        bus_err;
  logic [63:0] stall_cycles, flush_cnt;

  int checks = 0;
  int errors = 0;

  int              m_state;
  bit              m_kill;
  int              m_wait;
  longint unsigned m_stall, m_flush;

  typedef struct {
    logic [5:0]  stim;
    logic [11:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  ysyx_22051013_pipe_ctl #(.LS_TIMEOUT(LS_TO), .TCNT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .if_ready_i(if_ready), .id_load_use_i(ld_use), .id_jump_i(jump),
    .ex_busy_i(ex_busy), .ls_req_i(ls_req), .ls_ack_i(ls_ack),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .idex_en_o(idex_en),
    .exls_en_o(exls_en), .lswb_en_o(lswb_en),
    .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
    .exls_flush_o(exls_flush), .lswb_flush_o(lswb_flush),
    .state_o(state), .bus_err_o(bus_err),
    .stall_cycles_o(stall_cycles), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  // Packed view: {state[1:0], bus_err, pc_en, en ifid/idex/exls/lswb, flush ifid/idex/exls/lswb}
  function automatic logic [11:0] ctl_now();
    return {state, bus_err, pc_en, ifid_en, idex_en, exls_en, lswb_en,
            ifid_flush, idex_flush, exls_flush, lswb_flush};
  endfunction

  // Stimulus packing: {if_ready, load_use, jump, ex_busy, ls_req, ls_ack}
  function automatic int cause_of(input logic [5:0] s);
    if (m_state == 3)        return 0;
    if (s[1] && !s[0])       return 1;
    if (s[2])                return 2;
    if (s[4])                return 3;
    if (s[3])                return 4;
    return 5;
  endfunction

  function automatic logic [11:0] model_out(input logic [5:0] s);
    logic [1:0] st;
    logic       fetch;
    st    = 2'(m_state);
    fetch = s[5] && !m_kill;
    case (cause_of(s))
      0:       return 12'b11_1_0_0000_1111;
      1:       return {st, 2'b00, 4'b0000, 4'b0001};
      2:       return {st, 2'b00, 4'b0001, 4'b0010};
      3:       return {st, 2'b00, 4'b0011, 4'b0100};
      4:       return {st, 2'b01, 4'b0111, 4'b1000};
      default: return {st, 1'b0, fetch, 4'b1111, !fetch, 3'b000};
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_kill = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_step(input logic [5:0] s);
    int         c;
    logic [11:0] o;
    logic       ifr, exb, req, ack;
    ifr = s[5]; exb = s[2]; req = s[1]; ack = s[0];
    c = cause_of(s);
    o = model_out(s);
    if (!o[8]) m_stall++;
    if (c == 4 || (c == 5 && m_kill && ifr)) m_flush++;
    if (c == 0)                              m_kill = 1'b0;
    else if (c == 4 && (!ifr || m_kill))     m_kill = 1'b1;
    else if (m_kill && ifr)                  m_kill = 1'b0;
    case (m_state)
      0, 1: begin
        if (req && !ack) begin m_state = 2; m_wait = 0; end
        else if (m_state == 0 && exb) m_state = 1;
        else if (m_state == 1 && !exb) m_state = 0;
      end
      2: begin
        if (ack || !req) m_state = 0;
        else if (m_wait + 1 == LS_TO) m_state = 3;
        else m_wait++;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_perf(input string name);
`ifdef PIPE_CTL_PERF_EN
    checkOutput({name, "_stall_cnt"}, stall_cycles, m_stall);
    checkOutput({name, "_flush_cnt"}, flush_cnt, m_flush);
`else
    checkOutput({name, "_stall_cnt"}, stall_cycles, 64'd0);
    checkOutput({name, "_flush_cnt"}, flush_cnt, 64'd0);
`endif
  endtask

  task automatic applyStimulus(input logic [5:0] s);
    @(negedge clk);
    {if_ready, ld_use, jump, ex_busy, ls_req, ls_ack} = s;
    #1;
  endtask

  task automatic run_cycle(input logic [5:0] s, input logic [11:0] exp, input string name);
    applyStimulus(s);
    checkOutput(name, {52'd0, ctl_now()}, {52'd0, exp});
    check_perf(name);
    model_step(s);
  endtask

  task automatic add(input logic [5:0] s, input logic [11:0] e, input int n, input string name);
    vec_t v;
    v.stim = s; v.exp = e; v.name = name;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    bit r_if, r_lu, r_j, r_ex, r_req, r_ack, req_hold;
    int starve;

    add(6'b100000, 12'b00_0_1_1111_0000, 1, "fetch");
    add(6'b000000, 12'b00_0_0_1111_1000, 1, "idle");
    add(6'b110000, 12'b00_0_0_0011_0100, 1, "load_use");
    add(6'b100000, 12'b00_0_1_1111_0000, 1, "after_lu");
    add(6'b001000, 12'b00_0_1_0111_1000, 1, "jump_nofetch");
    add(6'b000000, 12'b00_0_0_1111_1000, 1, "kill_idle");
    add(6'b100000, 12'b00_0_0_1111_1000, 1, "kill_drop");
    add(6'b100000, 12'b00_0_1_1111_0000, 1, "post_kill");
    add(6'b101000, 12'b00_0_1_0111_1000, 1, "jump_fetch");
    add(6'b100000, 12'b00_0_1_1111_0000, 1, "after_jump_fetch");
    add(6'b001000, 12'b00_0_1_0111_1000, 1, "jump_nofetch2");
    add(6'b101000, 12'b00_0_1_0111_1000, 1, "jump_while_kill");
    add(6'b100000, 12'b00_0_0_1111_1000, 1, "kill_drop2");
    add(6'b100000, 12'b00_0_1_1111_0000, 1, "post_kill2");
    add(6'b101100, 12'b00_0_0_0001_0010, 1, "ex_busy_run");
    add(6'b101100, 12'b01_0_0_0001_0010, 4, "ex_busy_wait");
    add(6'b101000, 12'b01_0_1_0111_1000, 1, "ex_release_jump");
    add(6'b100000, 12'b00_0_1_1111_0000, 1, "after_ex");
    add(6'b000010, 12'b00_0_0_0000_0001, 1, "ls_run");
    add(6'b000010, 12'b10_0_0_0000_0001, 9, "ls_wait");
    add(6'b000011, 12'b10_0_0_1111_1000, 1, "ls_ack");
    add(6'b000000, 12'b00_0_0_1111_1000, 1, "after_ls");
    add(6'b000010, 12'b00_0_0_0000_0001, 1, "to_run");
    add(6'b000010, 12'b10_0_0_0000_0001, LS_TO, "to_wait");
    add(6'b000000, 12'b11_1_0_0000_1111, 1, "to_err");
    add(6'b000000, 12'b00_0_0_1111_1000, 1, "after_err");
    add(6'b000010, 12'b00_0_0_0000_0001, 1, "ack_run");
    add(6'b000010, 12'b10_0_0_0000_0001, LS_TO - 1, "ack_wait");
    add(6'b000011, 12'b10_0_0_1111_1000, 1, "ack_last");
    add(6'b000000, 12'b00_0_0_1111_1000, 1, "ack_after");
    add(6'b001000, 12'b00_0_1_0111_1000, 1, "err_jump");
    add(6'b000010, 12'b00_0_0_0000_0001, 1, "err_run");
    add(6'b000010, 12'b10_0_0_0000_0001, LS_TO, "err_wait");
    add(6'b000000, 12'b11_1_0_0000_1111, 1, "err_pulse");
    add(6'b100000, 12'b00_0_1_1111_0000, 1, "err_fetch");
    add(6'b000010, 12'b00_0_0_0000_0001, 1, "drop_run");
    add(6'b000000, 12'b10_0_0_1111_1000, 1, "drop_req");
    add(6'b000000, 12'b00_0_0_1111_1000, 1, "drop_after");
    add(6'b000100, 12'b00_0_0_0001_0010, 1, "exls_run");
    add(6'b000110, 12'b01_0_0_0000_0001, 1, "exls_ls");
    add(6'b000011, 12'b10_0_0_1111_1000, 1, "exls_ack");
    add(6'b000110, 12'b00_0_0_0000_0001, 1, "both_run");
    add(6'b000101, 12'b10_0_0_0001_0010, 1, "both_ack");
    add(6'b000000, 12'b00_0_0_1111_1000, 1, "both_end");

    {if_ready, ld_use, jump, ex_busy, ls_req, ls_ack} = 6'b111111;
    #3;
    checkOutput("reset_ctl", {52'd0, ctl_now()}, {52'd0, 12'b00_0_0_0000_1111});
    model_reset();
    check_perf("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    {if_ready, ld_use, jump, ex_busy, ls_req, ls_ack} = 6'b000000;

    foreach (vecs[i]) run_cycle(vecs[i].stim, vecs[i].exp, vecs[i].name);

    run_cycle(6'b000010, 12'b00_0_0_0000_0001, "mr_run");
    run_cycle(6'b001010, 12'b10_0_0_0000_0001, "mr_wait");
    applyStimulus(6'b000010);
    #1 rst = 1'b0;
    #1;
    checkOutput("mr_reset_ctl", {52'd0, ctl_now()}, {52'd0, 12'b00_0_0_0000_1111});
    model_reset();
    check_perf("mr_reset");
    {if_ready, ld_use, jump, ex_busy, ls_req, ls_ack} = 6'b000000;
    @(negedge clk);
    rst = 1'b1;
    run_cycle(6'b100000, 12'b00_0_1_1111_0000, "mr_after");

    req_hold = 1'b0;
    starve   = 0;
    for (int i = 0; i < 1500; i++) begin
      if (starve > 0) starve--;
      else if ($urandom_range(0, 39) == 0) starve = LS_TO + 2;
      r_if  = 1'($urandom_range(0, 1));
      r_lu  = ($urandom_range(0, 5) == 0);
      r_j   = ($urandom_range(0, 3) == 0);
      r_ex  = ($urandom_range(0, 4) == 0);
      r_req = req_hold || ($urandom_range(0, 3) == 0);
      r_ack = (starve == 0) && ($urandom_range(0, 2) == 0);
      req_hold = r_req && !r_ack;
      run_cycle({r_if, r_lu, r_j, r_ex, r_req, r_ack},
                model_out({r_if, r_lu, r_j, r_ex, r_req, r_ack}), "rand_ctl");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_pipe_ctl.md
Name: ysyx_22051013_pipe_ctl

Overview:
Central pipeline sequencer for the 5-stage core (IF/ID/EX/LS/WB). It generates per-boundary enable and flush controls from decode hazards (load-use, redirect), the multi-cycle EXU busy signal, and fetch and LSU memory handshakes. It tracks a wrong-path fetch that is still in flight, and times out hung LSU accesses. It replaces the scattered ready/flush glue between stages.

Parameters:
LS_TIMEOUT, 255, max LS_WAIT cycles before bus error (>=2)
TCNT_W, 8, width of timeout counter (must hold LS_TIMEOUT)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
if_ready_i  in  1  fetch handshake complete, instruction valid this cycle
id_load_use_i  in  1  decode load-use hazard
id_jump_i  in  1  decode redirect (jump/branch mispredict), target on decode jump_pc
ex_busy_i  in  1  multi-cycle EX op not finished
ls_req_i  in  1  LSU access in flight
ls_ack_i  in  1  LSU memory ack
pc_en_o  out  1  PC update enable
ifid_en_o / idex_en_o / exls_en_o / lswb_en_o  out  1 each  pipeline-register load enables
ifid_flush_o / idex_flush_o / exls_flush_o / lswb_flush_o  out  1 each  insert bubble into downstream stage
state_o  out  2  FSM state (RUN=0, EX_WAIT=1, LS_WAIT=2, ERR=3)
bus_err_o  out  1  one-cycle pulse on LSU timeout
stall_cycles_o  out  64  perf counter (see Optional Feature)
flush_cnt_o  out  64  perf counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=RUN, kill=0, tcnt=0. While rst=0, force all *_en=0, all *_flush=1, pc_en=0, bus_err_o=0, state_o=0, counters=0.
- Control outputs are combinational from state, kill, and inputs, with zero-cycle latency. State, kill, and counters update on posedge clk.
- Qualified events:
  - ls_stall = ls_req_i & ~ls_ack_i
  - ex_stall = ex_busy_i & ~ls_stall
  - lu = id_load_use_i & ~ls_stall & ~ex_busy_i
  - jmp = id_jump_i & ~ls_stall & ~ex_busy_i & ~id_load_use_i. A jump computed from stale or frozen operands is ignored until its stage is free.
  - fetch_ok = if_ready_i & ~kill
- Priority in RUN/EX_WAIT/LS_WAIT:
  - ls_stall: pc, ifid, idex, exls enables=0; lswb_flush=1.
  - ex_stall: pc, ifid, idex enables=0; exls_flush=1; lswb_en=1.
  - lu: pc_en=0, ifid_en=0; idex_flush=1; later stages enabled.
  - jmp: pc_en=1 (load target); ifid_flush=1; idex/exls/lswb enabled.
  - else: all stage enables=1. pc_en=fetch_ok. ifid_flush=~fetch_ok.
- Kill flag:
  - Set when jmp & ~if_ready_i (wrong-path fetch outstanding).
  - While kill=1, the next if_ready_i is dropped: ifid_flush=1, pc_en=0. kill clears that cycle.
  - jmp coincident with if_ready_i: instruction squashed via ifid_flush; kill not set.
  - jmp while kill=1: kill stays 1.
- FSM:
  - RUN -> LS_WAIT on ls_stall; RUN -> EX_WAIT on ex_stall.
  - EX_WAIT -> LS_WAIT on ls_stall; EX_WAIT -> RUN when ~ex_busy_i.
  - LS_WAIT -> RUN on ls_ack_i (or ~ls_req_i).
  - LS_WAIT -> ERR when tcnt==LS_TIMEOUT-1 and no ack. If ack arrives on the same cycle, ack wins.
  - ERR (1 cycle): bus_err_o=1; all four flushes=1; all enables=0; pc_en=0; kill<=0; next RUN.
- tcnt: cleared on entry to LS_WAIT, increments each LS_WAIT cycle, saturates, cleared when leaving LS_WAIT.
- Reset mid-operation aborts the current state immediately, with no pulse on bus_err_o.

Optional Feature:
PIPE_CTL_PERF_EN:
- Defined: stall_cycles_o counts cycles with pc_en_o=0 (including kill drops and ERR). flush_cnt_o counts cycles with ifid_flush_o=1 caused by jmp or kill. Both are 64-bit wrapping counters, reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are synthesized.

Test Plan:
- Load-use: id_load_use_i=1 for 1 cycle, if_ready_i=1 -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; next cycle all enables=1.
- Redirect with fetch outstanding: id_jump_i=1, if_ready_i=0 -> pc_en=1, ifid_flush=1, kill set. Next if_ready_i=1 -> ifid_flush=1, pc_en=0. Following if_ready_i is accepted normally.
- EX busy 5 cycles with concurrent id_jump_i=1 -> state_o=1 for 5 cycles, exls_flush=1, pc_en=0, jump masked. Jump is taken the cycle ex_busy_i falls.
- LSU ack after 10 cycles -> state_o=2 for 10 cycles, lswb_flush=1, exls_en=0. Returns to RUN, bus_err_o stays 0.
- LS_TIMEOUT=4, ls_req_i held, no ack -> state_o=2 for 4 cycles, then ERR with bus_err_o=1 and all flushes=1 for 1 cycle, then RUN. Repeat with ack on cycle 4 -> no ERR.
- With PIPE_CTL_PERF_EN: the above sequence -> stall_cycles_o and flush_cnt_o match the counted cycles. Assert rst=0 mid-LS_WAIT -> counters and state cleared asynchronously.
